// File: rtl/rv32i_pipe_ctrl_if.sv
// Handshake bundle between the RV32i pipeline sequencer and its requesters (hazard unit,
// imem/dmem handshakes) and consumers (stage registers).
interface rv32i_pipe_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int TIMEOUT_W  = 8
);
    logic                  issue_i;
    logic [NUM_STAGES-1:0] stall_req_i;
    logic [NUM_STAGES-1:0] flush_req_i;
    logic [NUM_STAGES-1:0] en_o;
    logic [NUM_STAGES-1:0] valid_o;
    logic                  retire_o;
    logic [TIMEOUT_W-1:0]  stall_cnt_o;
    logic                  timeout_o;

    modport master (
        output issue_i, stall_req_i, flush_req_i,
        input  en_o, valid_o, retire_o, stall_cnt_o, timeout_o
    );

    modport slave (
        input  issue_i, stall_req_i, flush_req_i,
        output en_o, valid_o, retire_o, stall_cnt_o, timeout_o
    );
endinterface

// File: rtl/rv32i_pipe_ctrl.sv
// Pipeline sequencer: turns per-stage stall/flush requests into stage register enables and
// valid bits, with optional bubble collapse and a sticky stall watchdog.
module rv32i_pipe_ctrl #(
    parameter int NUM_STAGES      = 5,
    parameter int BUBBLE_COLLAPSE = 1,
    parameter int TIMEOUT_W       = 8,
    parameter int TIMEOUT         = 200
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv32i_pipe_ctrl_if.slave   bus
);
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]          TO_VAL  = TIMEOUT;

    logic [NUM_STAGES-1:0] r_valid;
    logic [TIMEOUT_W-1:0]  r_stall_cnt;
    logic                  r_timeout;

    logic [NUM_STAGES-1:0] w_req;
    logic [NUM_STAGES-1:0] w_fl;
    logic [NUM_STAGES-1:0] w_hold;
    logic [NUM_STAGES-1:0] w_fl_at;     // a live flush at this stage or any older one
    logic [NUM_STAGES-1:0] w_fl_above;  // a live flush strictly older than this stage
    logic [NUM_STAGES-1:0] w_in;
    logic [NUM_STAGES-1:0] w_valid_next;
    logic                  w_held;
    logic [31:0]           w_cnt_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_req
            assign w_req[gi] = bus.stall_req_i[gi] & r_valid[gi];
            assign w_fl[gi]  = bus.flush_req_i[gi] & r_valid[gi];
        end
    endgenerate

    // Hold and flush reach propagate from writeback toward fetch.
    always_comb begin
        logic v_hold_acc;
        logic v_fl_acc;
        w_hold     = '0;
        w_fl_at    = '0;
        w_fl_above = '0;
        v_hold_acc = 1'b0;
        v_fl_acc   = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (BUBBLE_COLLAPSE != 0) begin
                v_hold_acc = r_valid[k] & (w_req[k] | v_hold_acc);
            end else begin
                v_hold_acc = w_req[k] | v_hold_acc;
            end
            w_hold[k]     = v_hold_acc;
            w_fl_above[k] = v_fl_acc;
            v_fl_acc      = v_fl_acc | w_fl[k];
            w_fl_at[k]    = v_fl_acc;
        end
    end

    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_fetch
                assign w_in[gi] = bus.issue_i;
            end else begin : g_inner
                assign w_in[gi] = r_valid[gi-1] & ~w_hold[gi-1];
            end
            // Younger than the flusher: cleared. The flusher itself only drops what it would load.
            assign w_valid_next[gi] = w_fl_above[gi] ? 1'b0 :
                                      (w_hold[gi] ? r_valid[gi] : (w_in[gi] & ~w_fl_at[gi]));
        end
    endgenerate

    assign w_held    = |w_hold;
    assign w_cnt_inc = {{(32 - TIMEOUT_W){1'b0}}, r_stall_cnt} + 32'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            if (w_held) begin
                if (r_stall_cnt != CNT_MAX) begin
                    r_stall_cnt <= r_stall_cnt + TIMEOUT_W'(1);
                end
                if ((TIMEOUT != 0) && (w_cnt_inc == TO_VAL)) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end
        end
    end

    assign bus.en_o        = rst_i ? '0 : ~w_hold;
    assign bus.retire_o    = ~rst_i & r_valid[NUM_STAGES-1] & ~w_hold[NUM_STAGES-1];
    assign bus.valid_o     = r_valid;
    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.timeout_o   = r_timeout;
endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Directed bench for rv32i_pipe_ctrl: a freeze-style instance (COLLAPSE=0, TIMEOUT=4) and a
// collapsing instance (COLLAPSE=1, TIMEOUT=200) driven with identical stimulus.
module tb_rv32i_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_pipe_ctrl_if #(.NUM_STAGES(5), .TIMEOUT_W(8)) bus0 ();
    rv32i_pipe_ctrl_if #(.NUM_STAGES(5), .TIMEOUT_W(8)) bus1 ();

    rv32i_pipe_ctrl #(.NUM_STAGES(5), .BUBBLE_COLLAPSE(0), .TIMEOUT_W(8), .TIMEOUT(4)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    rv32i_pipe_ctrl #(.NUM_STAGES(5), .BUBBLE_COLLAPSE(1), .TIMEOUT_W(8), .TIMEOUT(200)) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] sv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iss, input logic [4:0] st, input logic [4:0] fl);
        bus0.issue_i = iss; bus0.stall_req_i = st; bus0.flush_req_i = fl;
        bus1.issue_i = iss; bus1.stall_req_i = st; bus1.flush_req_i = fl;
    endtask

    // One clock: combinational outputs checked before the edge, valid bits after it.
    task automatic cyc(input string tag, input logic iss, input logic [4:0] st, input logic [4:0] fl,
                       input logic [4:0] en0, input logic r0, input logic [4:0] v0,
                       input logic [4:0] en1, input logic r1, input logic [4:0] v1);
        drive(iss, st, fl);
        #1;
        check({tag, ".en0"}, 32'(bus0.en_o), 32'(en0));
        check({tag, ".ret0"}, 32'(bus0.retire_o), 32'(r0));
        check({tag, ".en1"}, 32'(bus1.en_o), 32'(en1));
        check({tag, ".ret1"}, 32'(bus1.retire_o), 32'(r1));
        @(posedge clk);
        #1;
        check({tag, ".v0"}, 32'(bus0.valid_o), 32'(v0));
        check({tag, ".v1"}, 32'(bus1.valid_o), 32'(v1));
        $display("[TB] %s iss=%b st=%b fl=%b en0=%b en1=%b v0=%b v1=%b cnt0=%0d to0=%b",
                 tag, iss, st, fl, en0, en1, bus0.valid_o, bus1.valid_o,
                 bus0.stall_cnt_o, bus0.timeout_o);
    endtask

    task automatic cyc_same(input string tag, input logic iss, input logic [4:0] st,
                            input logic [4:0] fl, input logic [4:0] en, input logic r,
                            input logic [4:0] v);
        cyc(tag, iss, st, fl, en, r, v, en, r, v);
    endtask

    // Request-free cycle: the pipe just shifts, last stage retires if live.
    task automatic shift(input string tag, input logic iss);
        cyc_same(tag, iss, 5'b00000, 5'b00000, 5'b11111, sv[4], {sv[3:0], iss});
        sv = {sv[3:0], iss};
    endtask

    task automatic chk_wd(input string tag, input int c0, input logic t0, input int c1, input logic t1);
        check({tag, ".cnt0"}, 32'(bus0.stall_cnt_o), 32'(c0));
        check({tag, ".to0"}, 32'(bus0.timeout_o), 32'(t0));
        check({tag, ".cnt1"}, 32'(bus1.stall_cnt_o), 32'(c1));
        check({tag, ".to1"}, 32'(bus1.timeout_o), 32'(t1));
    endtask

    // Requests stay asserted through reset to show they leave nothing behind.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        drive(1'b1, 5'b10000, 5'b00100);
        #1;
        check({tag, ".en0"}, 32'(bus0.en_o), 32'd0);
        check({tag, ".ret0"}, 32'(bus0.retire_o), 32'd0);
        check({tag, ".en1"}, 32'(bus1.en_o), 32'd0);
        check({tag, ".ret1"}, 32'(bus1.retire_o), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({tag, ".v0"}, 32'(bus0.valid_o), 32'd0);
        check({tag, ".v1"}, 32'(bus1.valid_o), 32'd0);
        chk_wd(tag, 0, 1'b0, 0, 1'b0);
        $display("[TB] %s reset applied", tag);
        rst = 1'b0;
        drive(1'b0, 5'b00000, 5'b00000);
        sv = 5'b00000;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'b00000, 5'b00000);

        do_reset("rst0");
        for (int i = 0; i < 5; i++) shift("fill", 1'b1);
        shift("fill_ret", 1'b1);

        cyc_same("frz1", 1'b1, 5'b01000, 5'b00000, 5'b10000, 1'b1, 5'b01111);
        cyc_same("frz2", 1'b1, 5'b01000, 5'b00000, 5'b10000, 1'b0, 5'b01111);
        cyc_same("frz3", 1'b1, 5'b01000, 5'b00000, 5'b10000, 1'b0, 5'b01111);
        chk_wd("frz_cnt", 3, 1'b0, 3, 1'b0);
        cyc_same("frz_rel", 1'b1, 5'b00000, 5'b00000, 5'b11111, 1'b0, 5'b11111);
        chk_wd("frz_rel", 0, 1'b0, 0, 1'b0);
        sv = 5'b11111;

        shift("gap", 1'b0);
        shift("gap", 1'b1);
        shift("gap", 1'b1);
        check("gap_state", 32'(bus0.valid_o), 32'(5'b11011));
        cyc("coll", 1'b1, 5'b10000, 5'b00000,
            5'b00000, 1'b0, 5'b11011,
            5'b00111, 1'b0, 5'b11111);

        do_reset("rst1");
        for (int i = 0; i < 5; i++) shift("fill", 1'b1);

        cyc_same("flush", 1'b1, 5'b00000, 5'b00100, 5'b11111, 1'b1, 5'b11000);
        sv = 5'b11000;
        for (int i = 0; i < 5; i++) shift("refill", 1'b1);

        cyc_same("flst", 1'b1, 5'b10000, 5'b00100, 5'b00000, 1'b0, 5'b11100);
        chk_wd("flst", 1, 1'b0, 1, 1'b0);
        cyc_same("flst_rel", 1'b1, 5'b00000, 5'b00000, 5'b11111, 1'b1, 5'b11001);
        chk_wd("flst_rel", 0, 1'b0, 0, 1'b0);

        for (int i = 1; i <= 6; i++) begin
            cyc("wd", 1'b0, 5'b10000, 5'b00000,
                5'b00000, 1'b0, 5'b11001,
                (i <= 2) ? 5'b00111 : 5'b00011, 1'b0, (i == 1) ? 5'b11010 : 5'b11100);
            chk_wd("wd", i, (i >= 4), i, 1'b0);
        end
        cyc("wd_rel", 1'b0, 5'b00000, 5'b00000,
            5'b11111, 1'b1, 5'b10010,
            5'b11111, 1'b1, 5'b11000);
        chk_wd("wd_rel", 0, 1'b1, 0, 1'b0);

        do_reset("rst2");
        for (int i = 0; i < 5; i++) shift("fill", 1'b1);
        cyc_same("fl_wb", 1'b1, 5'b00000, 5'b10100, 5'b11111, 1'b1, 5'b00000);
        cyc_same("st_dead", 1'b1, 5'b00010, 5'b00000, 5'b11111, 1'b0, 5'b00001);
        cyc_same("fl_dead", 1'b1, 5'b00000, 5'b00010, 5'b11111, 1'b0, 5'b00011);
        cyc_same("fl_if", 1'b1, 5'b00000, 5'b00001, 5'b11111, 1'b0, 5'b00110);
        chk_wd("end", 0, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
